// File: rtl/alu_req_arbiter_if.sv
// alu_req_arbiter_if: requester-side handshake bundle for alu_req_arbiter.
// master = requester side, slave = arbiter side. Per-requester fields are packed
// slices, slice i belonging to requester i.
interface alu_req_arbiter_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OP_W  = 4,
  parameter int unsigned RES_W = 16
);
  localparam int unsigned IdW = $clog2(N);

  // Operation request channel
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*WIDTH-1:0] req_a;
  logic [N*WIDTH-1:0] req_b;
  logic [N*OP_W-1:0]  req_op;

  // Result response channel; result and id are shared, valid is one-hot
  logic [N-1:0]       rsp_valid;
  logic [N-1:0]       rsp_ready;
  logic [RES_W-1:0]   rsp_result;
  logic [IdW-1:0]     rsp_id;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_op,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_result,
    input  rsp_id
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_op,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_result,
    output rsp_id
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one sequential ALU among N requesters.
// One operation is in flight at a time: IDLE grants a requester and latches its
// operands onto the ALU inputs, EXEC waits out the ALU latency and captures the
// result, RESP holds the result until the owning requester accepts it.
// Build option: define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-first
// priority; otherwise grants rotate round-robin. Timing is identical in both.
module alu_req_arbiter #(
  parameter int unsigned N       = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned RES_W   = 16,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  alu_req_arbiter_if.slave   bus,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [OP_W-1:0]    alu_opcode,
  input  logic [RES_W-1:0]   alu_result,
  output logic               busy
);
  localparam int unsigned IdW  = $clog2(N);
  localparam int unsigned CntW = $clog2(ALU_LAT + 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]       state_q;
  logic [CntW-1:0]  cnt_q;
  logic [IdW-1:0]   rsp_id_q;
  logic [RES_W-1:0] rsp_result_q;

  logic [IdW-1:0]   rr_base;
  logic [IdW:0]     cand_sum;
  logic             grant_vld;
  logic [IdW-1:0]   grant_idx;
  logic [N-1:0]     grant_oh;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [OP_W-1:0]  sel_op;
  logic [N-1:0]     rsp_oh;
  logic             rsp_ack;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Fixed priority is a round-robin search that always starts at requester 0.
  assign rr_base = '0;
`else
  logic [IdW-1:0] rr_ptr_q;
  logic [IdW-1:0] next_ptr;

  assign next_ptr = (rsp_id_q == IdW'(N - 1)) ? '0 : rsp_id_q + IdW'(1);
  assign rr_base  = rr_ptr_q;

  // Search pointer moves just past the requester whose result was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (state_q == StResp && rsp_ack) begin
      rr_ptr_q <= next_ptr;
    end
  end
`endif

  // Round-robin search: walk downward so the lowest offset from rr_base wins.
  always_comb begin
    cand_sum  = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      cand_sum = {1'b0, rr_base} + (IdW + 1)'(k);
      if (cand_sum >= (IdW + 1)'(N)) begin
        cand_sum = cand_sum - (IdW + 1)'(N);
      end
      if (bus.req_valid[cand_sum[IdW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand_sum[IdW-1:0];
      end
    end
  end

  // Decode the grant to one-hot and mux out the granted requester's operands.
  always_comb begin
    grant_oh = '0;
    sel_a    = '0;
    sel_b    = '0;
    sel_op   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant_idx == IdW'(i)) begin
        grant_oh[i] = grant_vld;
        sel_a       = bus.req_a[i*WIDTH +: WIDTH];
        sel_b       = bus.req_b[i*WIDTH +: WIDTH];
        sel_op      = bus.req_op[i*OP_W +: OP_W];
      end
    end
  end

  // One-hot of the current result owner; drives rsp_valid and picks its rsp_ready.
  always_comb begin
    rsp_oh = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (rsp_id_q == IdW'(i)) begin
        rsp_oh[i] = 1'b1;
      end
    end
  end

  // Only the owner's rsp_ready counts; other bits are ignored.
  assign rsp_ack = |(bus.rsp_ready & rsp_oh);

  // req_ready is suppressed during reset so nothing looks accepted on a reset edge.
  assign bus.req_ready  = (state_q == StIdle && !rst) ? grant_oh : '0;
  assign bus.rsp_valid  = (state_q == StResp) ? rsp_oh : '0;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_id     = rsp_id_q;
  assign busy           = (state_q != StIdle);

  // Main sequencer: accept, wait ALU_LAT+1 edges, capture, hold until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_opcode   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_vld) begin
            alu_a      <= sel_a;
            alu_b      <= sel_b;
            alu_opcode <= sel_op;
            rsp_id_q   <= grant_idx;
            cnt_q      <= '0;
            state_q    <= StExec;
          end
        end
        StExec: begin
          // The ALU samples one edge after accept, so the result lands at cnt == ALU_LAT.
          if (cnt_q == CntW'(ALU_LAT)) begin
            rsp_result_q <= alu_result;
            state_q      <= StResp;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: begin
          if (rsp_ack) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: table-driven, directed and randomized checks of alu_req_arbiter
// against a transaction-level reference model. Two instances: ALU latency 1 and 3.
module tb_alu_req_arbiter;
  localparam int N = 4, WIDTH = 8, OP_W = 4, RES_W = 16, LAT = 1, LAT3 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_req_arbiter_if #(.N(N), .WIDTH(WIDTH), .OP_W(OP_W), .RES_W(RES_W)) bus ();
  alu_req_arbiter_if #(.N(N), .WIDTH(WIDTH), .OP_W(OP_W), .RES_W(RES_W)) bus3 ();

  logic [WIDTH-1:0] alu_a, alu_b, alu3_a, alu3_b;
  logic [OP_W-1:0]  alu_op, alu3_op;
  logic [RES_W-1:0] alu_res, alu3_res;
  logic             busy, busy3;

  alu_req_arbiter #(.N(N), .WIDTH(WIDTH), .OP_W(OP_W), .RES_W(RES_W), .ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_op),
    .alu_result(alu_res), .busy(busy)
  );

  alu_req_arbiter #(.N(N), .WIDTH(WIDTH), .OP_W(OP_W), .RES_W(RES_W), .ALU_LAT(LAT3)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .alu_a(alu3_a), .alu_b(alu3_b), .alu_opcode(alu3_op),
    .alu_result(alu3_res), .busy(busy3)
  );

  // Behavioural ALU used both as the stub and as the expected-result source.
  function automatic logic [RES_W-1:0] ref_alu(logic [7:0] a, logic [7:0] b, logic [3:0] op);
    case (op)
      4'd0:    return {8'h00, a} + {8'h00, b};
      4'd1:    return {8'h00, a} - {8'h00, b};
      4'd2:    return {8'h00, a & b};
      4'd3:    return {8'h00, a | b};
      4'd4:    return {8'h00, a ^ b};
      4'd5:    return {8'h00, a} * {8'h00, b};
      default: return {b, a};
    endcase
  endfunction

  // Sequential ALU stubs: sample operands on an edge, result valid LAT edges later.
  logic [RES_W-1:0] pipe1 [LAT];
  logic [RES_W-1:0] pipe3 [LAT3];
  always @(posedge clk) begin
    pipe1[0] <= ref_alu(alu_a, alu_b, alu_op);
    for (int i = 1; i < LAT; i++) pipe1[i] <= pipe1[i-1];
    pipe3[0] <= ref_alu(alu3_a, alu3_b, alu3_op);
    for (int i = 1; i < LAT3; i++) pipe3[i] <= pipe3[i-1];
  end
  assign alu_res  = pipe1[LAT-1];
  assign alu3_res = pipe3[LAT3-1];

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0 && i < N) r[i] = 1'b1;
    return r;
  endfunction

  task automatic set_req(int i, logic [7:0] a, logic [7:0] b, logic [3:0] op);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
    bus.req_op[i*OP_W +: OP_W]  = op;
  endtask

  task automatic clear_inputs();
    bus.req_valid  = '0; bus.req_a  = '0; bus.req_b  = '0; bus.req_op  = '0; bus.rsp_ready  = '0;
    bus3.req_valid = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.req_op = '0; bus3.rsp_ready = '0;
  endtask

  // Leaves the bench at negedge+1 with rst low and all inputs idle.
  task automatic do_reset(int cycles);
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    bus.req_valid = '1;
    #1;
    chk("ready_during_rst", bus.req_ready, '0);
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("rst_hs", {bus.req_ready, bus.rsp_valid, busy}, '0);
    chk("rst_alu", {alu_a, alu_b, alu_op}, '0);
    chk("rst_rsp", {bus.rsp_result, bus.rsp_id}, '0);
  endtask

  // Counts negedges after the accept edge until rsp_valid shows up (bounded).
  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (bus.rsp_valid == '0 && n < 40);
  endtask

  task automatic run_rec(logic [N-1:0] mask, logic [7:0] a, logic [7:0] b, logic [3:0] op,
                         int exp_g);
    int n;
    for (int i = 0; i < N; i++) if (mask[i]) set_req(i, a + 8'(i), b, op);
    bus.req_valid = mask;
    #1;
    chk("tbl_grant", bus.req_ready, oh(exp_g));
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(n);
    chk("tbl_latency", n, LAT + 2);
    chk("tbl_rsp_valid", bus.rsp_valid, oh(exp_g));
    chk("tbl_rsp_id", bus.rsp_id, exp_g);
    chk("tbl_rsp_result", bus.rsp_result, ref_alu(a + 8'(exp_g), b, op));
    bus.rsp_ready = '1;
    @(negedge clk);
    bus.rsp_ready = '0;
    #1;
    chk("tbl_back_idle", {busy, bus.rsp_valid}, '0);
  endtask

  typedef struct {
    logic [N-1:0] mask;
    logic [7:0]   a;
    logic [7:0]   b;
    logic [3:0]   op;
    int           g_rr;
    int           g_fix;
  } vec_t;

  vec_t vt [8];

  // Reference model state (transaction level)
  int              m_owner, m_left, m_ptr, m_id;
  bit              m_resp;
  logic [7:0]      m_a, m_b;
  logic [3:0]      m_op;
  logic [RES_W-1:0] m_res;

  function automatic int pick(logic [N-1:0] v, int ptr);
    for (int k = 0; k < N; k++) if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic int grant_of(logic [N-1:0] v);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return pick(v, 0);
`else
    return pick(v, m_ptr);
`endif
  endfunction

  int n, seen, g, exp_g;
  logic [RES_W-1:0] exp_r;
  logic [N-1:0] acc, e_ready, e_rsp;
  int gi[$], gc[$];

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();

    // Single request, ALU_LAT=1: 5 + 3 = 8 three cycles after accept.
    do_reset(2);
    set_req(0, 8'h05, 8'h03, 4'd0);
    bus.req_valid = 4'b0001;
    #1;
    chk("a_ready", bus.req_ready, 4'b0001);
    @(posedge clk); #1;
    bus.req_valid = '0;
    wait_rsp(n);
    chk("a_latency", n, 3);
    chk("a_rsp_valid", bus.rsp_valid, 4'b0001);
    chk("a_rsp", {bus.rsp_result, bus.rsp_id}, {16'h0008, 2'd0});
    bus.rsp_ready = 4'b0001;
    @(negedge clk);
    bus.rsp_ready = '0;
    #1;
    chk("a_idle", {busy, bus.rsp_valid}, '0);
    chk("a_alu_held", {alu_a, alu_b}, {8'h05, 8'h03});

    // Grant-order table from a fresh reset; rr expectation follows the pointer chain.
    vt[0] = '{4'b0001, 8'h05, 8'h03, 4'd0, 0, 0};
    vt[1] = '{4'b1111, 8'h10, 8'h20, 4'd1, 1, 0};
    vt[2] = '{4'b0011, 8'hF0, 8'h3C, 4'd2, 0, 0};
    vt[3] = '{4'b1001, 8'hA5, 8'h0F, 4'd3, 3, 0};
    vt[4] = '{4'b1110, 8'h55, 8'hAA, 4'd4, 1, 1};
    vt[5] = '{4'b0100, 8'h0C, 8'h0D, 4'd5, 2, 2};
    vt[6] = '{4'b0110, 8'h12, 8'h34, 4'd6, 1, 1};
    vt[7] = '{4'b1000, 8'hFE, 8'h02, 4'd0, 3, 3};
    do_reset(1);
    for (int t = 0; t < 8; t++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      run_rec(vt[t].mask, vt[t].a, vt[t].b, vt[t].op, vt[t].g_fix);
`else
      run_rec(vt[t].mask, vt[t].a, vt[t].b, vt[t].op, vt[t].g_rr);
`endif
    end

    // Back-pressure: requester 2's result held while rsp_ready[2] is low.
    set_req(2, 8'h21, 8'h42, 4'd5);
    bus.req_valid = 4'b0100;
    #1;
    chk("bp_grant", bus.req_ready, 4'b0100);
    @(posedge clk); #1;
    set_req(0, 8'h11, 8'h22, 4'd0);
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 4'b0010;
    wait_rsp(n);
    chk("bp_latency", n, LAT + 2);
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", bus.rsp_valid, 4'b0100);
      chk("bp_result", bus.rsp_result, 16'h0882);
      chk("bp_no_ready", bus.req_ready, '0);
      @(negedge clk); #1;
    end
    bus.rsp_ready = 4'b0100;
    @(negedge clk); #1;
    bus.rsp_ready = '0;
    chk("bp_released", bus.rsp_valid, '0);
    chk("bp_next_grant", bus.req_ready, 4'b0001);

    // Reset mid-EXEC drops requester 0's operation and returns the pointer to 0.
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_state", {bus.rsp_valid, busy, alu_a}, '0);
    seen = 0;
    repeat (6) begin
      @(negedge clk); #1;
      if (bus.rsp_valid != '0) seen = 1;
    end
    chk("mid_rst_no_rsp", seen, 0);
    run_rec(4'b1010, 8'h30, 8'h07, 4'd1, 1);

    // All four requesters held valid: rotation and one accept every 4 cycles.
    do_reset(1);
    for (int i = 0; i < N; i++) set_req(i, 8'(i * 3), 8'h01, 4'd0);
    bus.req_valid = '1;
    bus.rsp_ready = '1;
    for (int c = 0; c < 24; c++) begin
      #1;
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) begin gi.push_back(i); gc.push_back(c); end
      @(negedge clk);
    end
    chk("rr_grant_count", gi.size() >= 5, 1'b1);
    for (int k = 0; k < 5; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = k % N;
`endif
      if (k < gi.size()) begin
        chk("rr_order", gi[k], exp_g);
        if (k > 0) chk("rr_spacing", gc[k] - gc[k-1], 4);
      end
    end

    // ALU_LAT=3 instance: requesters 1 and 3 both valid, 1 first.
    do_reset(1);
    bus3.req_a[1*WIDTH +: WIDTH] = 8'hFF; bus3.req_b[1*WIDTH +: WIDTH] = 8'h01;
    bus3.req_a[3*WIDTH +: WIDTH] = 8'h10; bus3.req_b[3*WIDTH +: WIDTH] = 8'h01;
    bus3.req_valid = 4'b1010;
    #1;
    chk("l3_grant1", bus3.req_ready, 4'b0010);
    @(posedge clk); #1;
    bus3.req_valid = 4'b1000;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (bus3.rsp_valid == '0 && n < 40);
    chk("l3_latency", n, LAT3 + 2);
    chk("l3_rsp1", {bus3.rsp_valid, bus3.rsp_id, bus3.rsp_result}, {4'b0010, 2'd1, 16'h0100});
    bus3.rsp_ready = '1;
    @(negedge clk); #1;
    chk("l3_grant3", bus3.req_ready, 4'b1000);
    @(posedge clk); #1;
    bus3.req_valid = '0;
    n = 0;
    do begin @(negedge clk); #1; n++; end while (bus3.rsp_valid == '0 && n < 40);
    chk("l3_rsp3", {bus3.rsp_valid, bus3.rsp_id, bus3.rsp_result}, {4'b1000, 2'd3, 16'h0011});

    // Randomized traffic against the transaction-level model.
    do_reset(1);
    m_owner = -1; m_resp = 0; m_ptr = 0; m_id = 0; m_left = 0;
    m_a = '0; m_b = '0; m_op = '0; m_res = '0;
    acc = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && !acc[i]) begin
          if ($urandom_range(0, 7) == 0) bus.req_valid[i] = 1'b0;
        end else begin
          bus.req_valid[i] = ($urandom_range(0, 2) == 0);
          set_req(i, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 7)));
        end
      end
      bus.rsp_ready = N'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      #1;
      g = grant_of(bus.req_valid);
      e_ready = (!rst && m_owner < 0) ? oh(g) : '0;
      e_rsp   = m_resp ? oh(m_owner) : '0;
      chk("rand_hs", {bus.req_ready, bus.rsp_valid, busy}, {e_ready, e_rsp, m_owner >= 0});
      chk("rand_alu", {alu_a, alu_b, alu_op}, {m_a, m_b, m_op});
      chk("rand_rsp", {bus.rsp_result, bus.rsp_id}, {m_res, 2'(m_id)});
      @(posedge clk);
      acc = '0;
      if (rst) begin
        m_owner = -1; m_resp = 0; m_ptr = 0; m_id = 0;
        m_a = '0; m_b = '0; m_op = '0; m_res = '0;
      end else if (m_owner < 0) begin
        if (g >= 0) begin
          acc[g]  = 1'b1;
          m_owner = g;
          m_id    = g;
          m_a     = bus.req_a[g*WIDTH +: WIDTH];
          m_b     = bus.req_b[g*WIDTH +: WIDTH];
          m_op    = bus.req_op[g*OP_W +: OP_W];
          m_left  = LAT + 1;
        end
      end else if (!m_resp) begin
        m_left--;
        if (m_left == 0) begin
          m_res  = ref_alu(m_a, m_b, m_op);
          m_resp = 1;
        end
      end else if (bus.rsp_ready[m_owner]) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_resp  = 0;
      end
      @(negedge clk);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Shares one Sequential_ALU among N requesters. Each requester issues an operation (A, B, opcode) over a valid/ready handshake. The arbiter grants one requester at a time, round-robin. It drives the ALU operands, waits out the ALU latency, captures the result and returns it to the granted requester over a response handshake. It sits between the requester ports and the single ALU instance, and is the only driver of the ALU operand and opcode inputs.

## Interface
- N, default 4: number of requesters (2..8).
- WIDTH, default 8: operand width.
- OP_W, default 4: opcode width.
- RES_W, default 16: ALU result width.
- ALU_LAT, default 1: ALU latency in clock edges from operand sample to valid Result (≥1).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  N  per-requester operation valid.
- req_ready  out  N  one-hot accept; high only for the granted requester in IDLE.
- req_a  in  N*WIDTH  operand A; slice i belongs to requester i.
- req_b  in  N*WIDTH  operand B; slice i belongs to requester i.
- req_op  in  N*OP_W  opcode; slice i belongs to requester i.
- rsp_valid  out  N  one-hot result valid for the owning requester.
- rsp_ready  in  N  per-requester result accept.
- rsp_result  out  RES_W  captured ALU result; shared by all requesters.
- rsp_id  out  $clog2(N)  index of the requester that owns rsp_result.
- alu_a  out  WIDTH  drives ALU A.
- alu_b  out  WIDTH  drives ALU B.
- alu_opcode  out  OP_W  drives ALU opcode.
- alu_result  in  RES_W  ALU Result.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g = first i with req_valid[i] set, searching from rr_ptr upward with wrap-around.
  - req_ready[g] = 1 (combinational); all other bits are 0.
  - On the accepting edge: latch req_a/req_b/req_op slice g into alu_a/alu_b/alu_opcode; latch g into rsp_id; clear cnt; go to EXEC.
- EXEC:
  - Hold alu_* stable.
  - cnt increments each edge.
  - On the edge where cnt == ALU_LAT: rsp_result <= alu_result; go to RESP.
- RESP:
  - rsp_valid[rsp_id] = 1; rsp_result and rsp_id are held.
  - On the edge where rsp_ready[rsp_id] is high: clear rsp_valid; rr_ptr <= (rsp_id+1) mod N; go to IDLE.
  - rsp_ready bits of other requesters are ignored.
- A requester holds req_valid and its operands until req_ready. Dropping req_valid before grant is legal; that request is simply not served.
- alu_* keep their last values after an operation; they are not cleared.
- If no req_valid bit is set in IDLE: stay in IDLE; req_ready = 0.

## Timing
- Reset values:
  - State IDLE, rr_ptr = 0, cnt = 0.
  - req_ready = 0 while rst is high.
  - rsp_valid = 0, rsp_result = 0, rsp_id = 0.
  - alu_a = 0, alu_b = 0, alu_opcode = 0, busy = 0.
- Accept at edge E0:
  - The ALU samples the operands at E1.
  - alu_result is valid after E(ALU_LAT).
  - The arbiter captures it at E(ALU_LAT+1).
  - rsp_valid is high from the cycle after E(ALU_LAT+1).
- Minimum issue period per operation is ALU_LAT+3 cycles: accept, ALU_LAT EXEC cycles plus the capture edge, one RESP cycle, one IDLE cycle.
- Same-cycle request and response: there is no overlap. A new request is only accepted in IDLE.
- Simultaneous requests are resolved in a single cycle by the round-robin search.
- Wrap-around: after requester N-1 is served, rr_ptr = 0.
- Reset asserted mid-EXEC or mid-RESP:
  - The next edge forces the reset values.
  - The in-flight operation is dropped and no response is issued.
  - rr_ptr returns to 0.
- rsp_ready held low forever: the arbiter stays in RESP. This is the requester's responsibility.

## Configuration
- ALU_ARB_FIXED_PRIO_EN:
  - When defined: grant is fixed priority, lowest index wins. rr_ptr is removed and is treated as 0.
  - When undefined: round-robin as described above.
  - All timing is identical in both builds.

## Test plan
- Stub ALU (registered A+B, ALU_LAT=1). Reset for 2 cycles, then requester 0 sends A=8'h05, B=8'h03 → req_ready[0] high in the first cycle; rsp_valid[0] high 3 cycles after the accept edge; rsp_result=16'h0008, rsp_id=0.
- All 4 req_valid held high, rsp_ready all high → grants in the order 0,1,2,3,0; one accept every 4 cycles. With ALU_ARB_FIXED_PRIO_EN defined, requester 0 is granted every time.
- Requester 2 only, rsp_ready[2] held low for 5 cycles → rsp_valid[2] and rsp_result stay stable for 5 cycles; req_ready stays 0 for all requesters; rsp_ready[1]=1 has no effect.
- rst pulsed for 1 cycle during EXEC → next cycle rsp_valid=0, busy=0, alu_a=0; no response ever issues for the dropped operation; the next request from requester 3 is granted ahead of requester 1 only if requester 1 is idle (rr_ptr=0 search order).
- ALU_LAT=3 with the real Sequential_ALU, A=8'hFF, B=8'h01, and requesters 1 and 3 both valid → rsp_result matches the ALU reference model value; rsp_valid rises 5 cycles after accept; requester 3 is served after requester 1.
